// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage Beta-style core.
// Drives PC / IF_ID / ID_EX / EX_MEM enables, flushes and bubbles.
module pipe_ctrl #(
    parameter int REG_W       = 5,
    parameter int INIT_CYC    = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_ra,
    input  logic [REG_W-1:0] id_rb,
    input  logic             id_uses_ra,
    input  logic             id_uses_rb,
    input  logic             ex_ld,
    input  logic [REG_W-1:0] ex_rc,
    input  logic             id_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_en,
    output logic             mem_err,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam int IW = $clog2(INIT_CYC + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    logic [1:0]    state;
    logic [IW-1:0] init_cnt;
    logic [WW-1:0] wait_cnt;
    logic          hazard;
    logic          freeze;
    logic          go;

    // R31 always reads as zero, so it never creates a dependency
    assign hazard = id_valid & ex_ld & (ex_rc != '1) &
                    ((id_uses_ra & (id_ra == ex_rc)) |
                     (id_uses_rb & (id_rb == ex_rc)));

    assign freeze = mem_req & ~mem_ack;

    // go: the pipe is allowed to move this cycle
    assign go = ((state == S_RUN) & ~freeze) |
                ((state == S_WAIT) & mem_ack);

    assign ctrl_state = state;

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_en    = 1'b0;
        if (state == S_INIT) begin
            if_id_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_en     = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_en    = 1'b1;
        end else if (go) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            if (hazard) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end else if (id_branch_taken & id_valid) begin
                if_id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_INIT;
            init_cnt <= '0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                S_INIT: begin
                    if (init_cnt == IW'(INIT_CYC - 1)) begin
                        state    <= S_RUN;
                        init_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (freeze) begin
                        state    <= S_WAIT;
                        wait_cnt <= WW'(1);
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        state <= S_RUN;
                    end else if (wait_cnt == WW'(MEM_TIMEOUT)) begin
                        state   <= S_RUN;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if ((state != S_INIT) && !pc_en &&
                     (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
// Control bundle order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en}.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_ra;
    logic [4:0]  id_rb;
    logic        id_uses_ra;
    logic        id_uses_rb;
    logic        ex_ld;
    logic [4:0]  ex_rc;
    logic        id_branch_taken;
    logic        mem_req;
    logic        mem_ack;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_en;
    logic        id_ex_bubble;
    logic        ex_mem_en;
    logic        mem_err;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cycles;

    logic [5:0]  ctl;
    int          passes = 0;
    int          total  = 0;
    int          exp_stall = 0;

    localparam logic [5:0] C_INIT   = 6'b011111;
    localparam logic [5:0] C_RUN    = 6'b110101;
    localparam logic [5:0] C_LDUSE  = 6'b000111;
    localparam logic [5:0] C_BRANCH = 6'b111101;
    localparam logic [5:0] C_FREEZE = 6'b000000;

    assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en};

    pipe_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_ra           (id_ra),
        .id_rb           (id_rb),
        .id_uses_ra      (id_uses_ra),
        .id_uses_rb      (id_uses_rb),
        .ex_ld           (ex_ld),
        .ex_rc           (ex_rc),
        .id_branch_taken (id_branch_taken),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_en        (id_ex_en),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_en       (ex_mem_en),
        .mem_err         (mem_err),
        .ctrl_state      (ctrl_state),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic idle();
        reset = 0; id_valid = 0; id_ra = 0; id_rb = 0;
        id_uses_ra = 0; id_uses_rb = 0; ex_ld = 0; ex_rc = 0;
        id_branch_taken = 0; mem_req = 0; mem_ack = 0;
    endtask

    // advance one clock; inputs change at posedge+1, checks happen at posedge+2
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        cyc();
        reset = 0;
        #1;
        total++;
        if (ctrl_state !== 2'd0 || stall_cycles !== 16'd0 || mem_err !== 1'b0) begin
            $display("FAIL reset_state act st=%0d stall=%0d err=%b req st=0 stall=0 err=0",
                     ctrl_state, stall_cycles, mem_err);
        end else passes++;
        // INIT must ignore hazards, branches and memory requests
        for (int i = 0; i < 4; i++) begin
            mem_req = 1; id_valid = 1; id_branch_taken = 1;
            ex_ld = 1; ex_rc = 2; id_ra = 2; id_uses_ra = 1;
            #1;
            total++;
            if (ctl !== C_INIT || ctrl_state !== 2'd0) begin
                $display("FAIL init_cyc%0d act ctl=%b st=%0d req ctl=%b st=0",
                         i, ctl, ctrl_state, C_INIT);
            end else passes++;
            if (i == 3) idle();
            cyc();
        end
        total++;
        if (ctl !== C_RUN || ctrl_state !== 2'd1 || stall_cycles !== 16'd0) begin
            $display("FAIL init_exit act ctl=%b st=%0d stall=%0d req ctl=%b st=1 stall=0",
                     ctl, ctrl_state, stall_cycles, C_RUN);
        end else passes++;
    endtask

    task automatic test_load_use();
        ex_ld = 1; ex_rc = 3; id_ra = 3; id_uses_ra = 1; id_valid = 1;
        #1;
        total++;
        if (ctl !== C_LDUSE) begin
            $display("FAIL ld_use_ra act=%b req=%b", ctl, C_LDUSE);
        end else passes++;
        exp_stall++;
        cyc();
        ex_ld = 0;
        #1;
        total++;
        if (ctl !== C_RUN || stall_cycles !== 16'(exp_stall)) begin
            $display("FAIL ld_use_after act ctl=%b stall=%0d req ctl=%b stall=%0d",
                     ctl, stall_cycles, C_RUN, exp_stall);
        end else passes++;
        cyc();
        // source B through the RA2SEL mux
        ex_ld = 1; ex_rc = 7; id_ra = 1; id_rb = 7;
        id_uses_ra = 1; id_uses_rb = 1;
        #1;
        total++;
        if (ctl !== C_LDUSE) begin
            $display("FAIL ld_use_rb act=%b req=%b", ctl, C_LDUSE);
        end else passes++;
        exp_stall++;
        cyc();
        // matching index but operand not read
        id_uses_rb = 0;
        #1;
        total++;
        if (ctl !== C_RUN) begin
            $display("FAIL ld_use_unused act=%b req=%b", ctl, C_RUN);
        end else passes++;
        cyc();
        ex_rc = 5'd31; id_ra = 5'd31; id_uses_ra = 1;
        #1;
        total++;
        if (ctl !== C_RUN) begin
            $display("FAIL ld_use_r31 act=%b req=%b", ctl, C_RUN);
        end else passes++;
        cyc();
        // hazard wins over a taken branch
        ex_rc = 4; id_ra = 4; id_branch_taken = 1;
        #1;
        total++;
        if (ctl !== C_LDUSE) begin
            $display("FAIL ld_use_branch act=%b req=%b", ctl, C_LDUSE);
        end else passes++;
        exp_stall++;
        cyc();
        idle();
        #1;
        total++;
        if (stall_cycles !== 16'(exp_stall)) begin
            $display("FAIL ld_use_count act=%0d req=%0d", stall_cycles, exp_stall);
        end else passes++;
    endtask

    task automatic test_branch();
        id_valid = 1; id_branch_taken = 1;
        #1;
        total++;
        if (ctl !== C_BRANCH) begin
            $display("FAIL branch_flush act=%b req=%b", ctl, C_BRANCH);
        end else passes++;
        cyc();
        id_valid = 0;
        #1;
        total++;
        if (ctl !== C_RUN) begin
            $display("FAIL branch_invalid act=%b req=%b", ctl, C_RUN);
        end else passes++;
        cyc();
        idle();
    endtask

    task automatic test_mem_wait();
        mem_req = 1; mem_ack = 1;
        #1;
        total++;
        if (ctl !== C_RUN) begin
            $display("FAIL mem_same_cyc act=%b req=%b", ctl, C_RUN);
        end else passes++;
        cyc();
        total++;
        if (ctrl_state !== 2'd1) begin
            $display("FAIL mem_same_state act=%0d req=1", ctrl_state);
        end else passes++;
        mem_ack = 0;
        #1;
        total++;
        if (ctl !== C_FREEZE || ctrl_state !== 2'd1) begin
            $display("FAIL mem_entry act ctl=%b st=%0d req ctl=%b st=1",
                     ctl, ctrl_state, C_FREEZE);
        end else passes++;
        exp_stall++;
        cyc();
        mem_req = 0;
        // hazard and branch must not leak through while frozen
        id_valid = 1; id_branch_taken = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (ctl !== C_FREEZE || ctrl_state !== 2'd2) begin
                $display("FAIL mem_wait%0d act ctl=%b st=%0d req ctl=%b st=2",
                         i, ctl, ctrl_state, C_FREEZE);
            end else passes++;
            exp_stall++;
            cyc();
        end
        mem_ack = 1;
        #1;
        total++;
        if (ctl !== C_BRANCH || ctrl_state !== 2'd2) begin
            $display("FAIL mem_ack_cyc act ctl=%b st=%0d req ctl=%b st=2",
                     ctl, ctrl_state, C_BRANCH);
        end else passes++;
        cyc();
        idle();
        #1;
        total++;
        if (ctrl_state !== 2'd1 || stall_cycles !== 16'(exp_stall)) begin
            $display("FAIL mem_release act st=%0d stall=%0d req st=1 stall=%0d",
                     ctrl_state, stall_cycles, exp_stall);
        end else passes++;
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        mem_req = 1;
        exp_stall++;
        cyc();
        mem_req = 0;
        for (int i = 1; i <= 64; i++) begin
            #1;
            if (ctrl_state !== 2'd2 || mem_err !== 1'b0) early++;
            exp_stall++;
            cyc();
        end
        total++;
        if (early != 0) begin
            $display("FAIL timeout_early act=%0d bad cycles req=0", early);
        end else passes++;
        #1;
        total++;
        if (mem_err !== 1'b1 || ctrl_state !== 2'd1 || ctl !== C_RUN) begin
            $display("FAIL timeout_pulse act err=%b st=%0d ctl=%b req err=1 st=1 ctl=%b",
                     mem_err, ctrl_state, ctl, C_RUN);
        end else passes++;
        cyc();
        total++;
        if (mem_err !== 1'b0 || stall_cycles !== 16'(exp_stall)) begin
            $display("FAIL timeout_end act err=%b stall=%0d req err=0 stall=%0d",
                     mem_err, stall_cycles, exp_stall);
        end else passes++;
    endtask

    task automatic test_reset_in_wait();
        mem_req = 1;
        cyc();
        mem_req = 0;
        for (int i = 1; i < 10; i++) cyc();
        total++;
        if (ctrl_state !== 2'd2) begin
            $display("FAIL rst_wait_pre act=%0d req=2", ctrl_state);
        end else passes++;
        reset = 1; mem_ack = 1;
        cyc();
        idle();
        #1;
        total++;
        if (ctrl_state !== 2'd0 || stall_cycles !== 16'd0 ||
            ctl !== C_INIT || mem_err !== 1'b0) begin
            $display("FAIL rst_wait act st=%0d stall=%0d ctl=%b err=%b req st=0 stall=0 ctl=%b err=0",
                     ctrl_state, stall_cycles, ctl, mem_err, C_INIT);
        end else passes++;
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencer for the 5-stage Beta-style core. It drives enable, flush and bubble controls for the PC and the IF_ID / ID_EX / EX_MEM pipeline registers. It resolves load-use hazards, taken-branch squashes and multi-cycle data-memory waits, and holds the pipe in NOP-fill after reset. It sits beside the datapath, taking decode and memory status and returning per-stage control.

Parameters:
REG_W, 5, register index width; index 31 (all ones) is R31, which is never a hazard source.
INIT_CYC, 4, cycles after reset during which the pipe is flushed with NOPs.
MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before an error abort.
CNT_W, 16, width of the stall statistics counter.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_ra  in  REG_W  ID source A index
id_rb  in  REG_W  ID source B index (after RA2SEL mux)
id_uses_ra  in  1  ID instruction reads ra
id_uses_rb  in  1  ID instruction reads rb
ex_ld  in  1  EX holds LD/LDR
ex_rc  in  REG_W  EX destination index
id_branch_taken  in  1  branch/JMP resolved taken in ID
mem_req  in  1  MEM stage starts a data access this cycle
mem_ack  in  1  data memory completes the access
pc_en  out  1  PC register load enable
if_id_en  out  1  IF_ID load enable
if_id_flush  out  1  load NOP into IF_ID
id_ex_en  out  1  ID_EX load enable
id_ex_bubble  out  1  load NOP into ID_EX
ex_mem_en  out  1  EX_MEM and MEM_WB load enable
mem_err  out  1  one-cycle pulse on memory timeout
ctrl_state  out  2  0=INIT, 1=RUN, 2=MEM_WAIT
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 in RUN/MEM_WAIT

Behaviour:
- State, counters and mem_err are registered. Per-stage controls are combinational from state and current inputs, so a stall takes effect in the same cycle.
- Reset (sampled at clk edge): state=INIT, init counter=0, wait counter=0, stall_cycles=0, mem_err=0.
- INIT: pc_en=0, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_bubble=1, ex_mem_en=1. After exactly INIT_CYC cycles in INIT, go to RUN. All other inputs are ignored.
- RUN default: all enables 1, flush=0, bubble=0.
- RUN priority 1, memory freeze: mem_req=1 and mem_ack=0.
  - pc_en=if_id_en=id_ex_en=ex_mem_en=0, no flush, no bubble.
  - Next state MEM_WAIT; wait counter←1.
  - mem_req=1 with mem_ack=1 in the same cycle means no freeze.
- RUN priority 2, load-use: hazard = id_valid & ex_ld & ex_rc≠31 & ((id_uses_ra & id_ra==ex_rc) | (id_uses_rb & id_rb==ex_rc)).
  - Response: pc_en=0, if_id_en=0, id_ex_bubble=1, id_ex_en=1, ex_mem_en=1.
  - Lasts exactly one cycle, because the load advances to MEM.
- RUN priority 3, branch squash: id_branch_taken & id_valid & no hazard gives if_id_flush=1, pc_en=1. The taken branch is ignored during a load-use stall (operands stale) and is re-evaluated next cycle.
- MEM_WAIT: all enables 0, no flush, no bubble; hazard and branch inputs are ignored.
  - mem_ack=1: this cycle behaves as RUN priorities 2–3 (memory released), next state RUN.
  - mem_ack=0 and wait counter==MEM_TIMEOUT: mem_err=1 for the next cycle, next state RUN, enables released in the following cycle. Otherwise the wait counter increments.
- stall_cycles increments each cycle with state≠INIT and pc_en=0, saturating at all ones.
- Reset mid-MEM_WAIT or mid-stall: immediate return to INIT next edge; a pending ack is discarded.

Test Plan:
- Reset 1 cycle, INIT_CYC=4 → if_id_flush=id_ex_bubble=1 and pc_en=0 for 4 cycles, then ctrl_state=1 with all enables 1.
- RUN, ex_ld=1, ex_rc=3, id_ra=3, id_uses_ra=1 → one cycle pc_en=0, if_id_en=0, id_ex_bubble=1; next cycle (ex_ld=0) normal; stall_cycles=1.
- Same with ex_rc=31, id_ra=31 → no stall. Same hazard plus id_branch_taken=1 → no flush that cycle.
- id_branch_taken=1, id_valid=1, no hazard → if_id_flush=1, pc_en=1 for one cycle.
- mem_req=1, mem_ack low 5 cycles then high → freeze 6 cycles (entry plus 5 in MEM_WAIT, ack cycle released), ctrl_state back to 1; mem_req & mem_ack same cycle → no freeze.
- MEM_TIMEOUT=64, mem_ack never → mem_err single pulse after 64 wait cycles, state RUN. Reset at wait cycle 10 → INIT, stall_cycles=0.
